// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller and the pipeline registers.
package hazard_pkg;

  typedef enum logic [1:0] {
    StRun      = 2'd0,
    StMemWait  = 2'd1,
    StRedirect = 2'd2
  } haz_state_e;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_WB  = 2'b10;

  // Canonical NOP (addi x0, x0, 0) loaded by a flushed pipeline register.
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [4:0]  NOP_RD    = 5'd0;

endpackage

// File: rtl/hazard_ctrl_fwd_unit.sv
// Forward-select for one EX operand; MEM result has priority over WB, x0 never forwards.
module fwd_unit
  import hazard_pkg::*;
#(
  parameter int unsigned REG_AW = 5
) (
  input  logic [REG_AW-1:0] rs,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic              mem_reg_write,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic              wb_reg_write,
  output logic [1:0]        sel
);

  always_comb begin
    sel = FWD_RF;
    if (mem_reg_write && (mem_rd != '0) && (mem_rd == rs)) begin
      sel = FWD_MEM;
    end else if (wb_reg_write && (wb_rd != '0) && (wb_rd == rs)) begin
      sel = FWD_WB;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline sequencing: stage enables, flushes, PC redirect and EX forwarding.
// Define HAZ_PERF_EN to add stall_cycles / redirect_count performance counters.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_uses_rs1,
  input  logic              id_uses_rs2,
  input  logic [REG_AW-1:0] ex_rs1,
  input  logic [REG_AW-1:0] ex_rs2,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_is_load,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic              mem_reg_write,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic              wb_reg_write,
  input  logic              ex_flush,
  input  logic [XLEN-1:0]   ex_pc_target,
  input  logic              dmem_busy,
  output logic              pc_en,
  output logic              if_id_en,
  output logic              id_ex_en,
  output logic              ex_mem_en,
  output logic              mem_wb_en,
  output logic              if_id_flush,
  output logic              id_ex_flush,
  output logic              redirect,
  output logic [XLEN-1:0]   redirect_pc,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b
`ifdef HAZ_PERF_EN
  ,
  output logic [31:0]       stall_cycles,
  output logic [31:0]       redirect_count
`endif
);

  haz_state_e      state_q;
  logic            pend_q;
  logic [XLEN-1:0] pend_pc_q;
  logic [1:0]      fwd_a_raw, fwd_b_raw;
  logic            lu;

  fwd_unit #(.REG_AW(REG_AW)) u_fwd_a (
    .rs            (ex_rs1),
    .mem_rd        (mem_rd),
    .mem_reg_write (mem_reg_write),
    .wb_rd         (wb_rd),
    .wb_reg_write  (wb_reg_write),
    .sel           (fwd_a_raw)
  );

  fwd_unit #(.REG_AW(REG_AW)) u_fwd_b (
    .rs            (ex_rs2),
    .mem_rd        (mem_rd),
    .mem_reg_write (mem_reg_write),
    .wb_rd         (wb_rd),
    .wb_reg_write  (wb_reg_write),
    .sel           (fwd_b_raw)
  );

  assign lu = ex_is_load && (ex_rd != '0) &&
              ((id_uses_rs1 && (id_rs1 == ex_rd)) || (id_uses_rs2 && (id_rs2 == ex_rd)));

  // A redirect must act in the same cycle as ex_flush, so outputs decode state and inputs.
  always_comb begin
    pc_en       = 1'b1;
    if_id_en    = 1'b1;
    id_ex_en    = 1'b1;
    ex_mem_en   = 1'b1;
    mem_wb_en   = 1'b1;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;
    redirect    = 1'b0;
    redirect_pc = '0;
    fwd_a       = fwd_a_raw;
    fwd_b       = fwd_b_raw;
    if (rst) begin
      {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en} = 5'b0;
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
      fwd_a       = FWD_RF;
      fwd_b       = FWD_RF;
    end else begin
      unique case (state_q)
        StRun: begin
          if (dmem_busy) begin
            {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en} = 5'b0;
          end else if (ex_flush) begin
            redirect    = 1'b1;
            redirect_pc = ex_pc_target;
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
          end else if (lu) begin
            pc_en       = 1'b0;
            if_id_en    = 1'b0;
            id_ex_flush = 1'b1;
          end
        end
        StMemWait: begin
          {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en} = 5'b0;
        end
        StRedirect: begin
          if (dmem_busy) begin
            {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en} = 5'b0;
          end else begin
            redirect    = 1'b1;
            redirect_pc = pend_pc_q;
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StRun;
      pend_q    <= 1'b0;
      pend_pc_q <= '0;
    end else begin
      unique case (state_q)
        StRun: begin
          if (dmem_busy) begin
            state_q <= StMemWait;
            if (ex_flush) begin
              pend_q    <= 1'b1;
              pend_pc_q <= ex_pc_target;
            end
          end
        end
        StMemWait: begin
          if (ex_flush) begin
            pend_q    <= 1'b1;
            pend_pc_q <= ex_pc_target;
          end
          if (!dmem_busy) begin
            state_q <= (pend_q || ex_flush) ? StRedirect : StRun;
          end
        end
        StRedirect: begin
          if (dmem_busy) begin
            state_q <= StMemWait;
          end else begin
            pend_q  <= 1'b0;
            state_q <= StRun;
          end
        end
        default: state_q <= StRun;
      endcase
    end
  end

`ifdef HAZ_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles   <= '0;
      redirect_count <= '0;
    end else begin
      if (!pc_en) stall_cycles <= stall_cycles + 32'd1;
      if (redirect) redirect_count <= redirect_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl; perf counters checked when HAZ_PERF_EN is defined.
module tb_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
  logic        id_uses_rs1, id_uses_rs2, ex_is_load, mem_reg_write, wb_reg_write;
  logic        ex_flush, dmem_busy;
  logic [31:0] ex_pc_target;
  logic        pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
  logic        if_id_flush, id_ex_flush, redirect;
  logic [31:0] redirect_pc;
  logic [1:0]  fwd_a, fwd_b;
`ifdef HAZ_PERF_EN
  logic [31:0] stall_cycles, redirect_count;
`endif

  int checks = 0;
  int errors = 0;

  logic [4:0] en;
  assign en = {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en};

  always #5 clk = ~clk;

  hazard_ctrl #(.XLEN(32), .REG_AW(5)) dut (
    .clk           (clk),
    .rst           (rst),
    .id_rs1        (id_rs1),
    .id_rs2        (id_rs2),
    .id_uses_rs1   (id_uses_rs1),
    .id_uses_rs2   (id_uses_rs2),
    .ex_rs1        (ex_rs1),
    .ex_rs2        (ex_rs2),
    .ex_rd         (ex_rd),
    .ex_is_load    (ex_is_load),
    .mem_rd        (mem_rd),
    .mem_reg_write (mem_reg_write),
    .wb_rd         (wb_rd),
    .wb_reg_write  (wb_reg_write),
    .ex_flush      (ex_flush),
    .ex_pc_target  (ex_pc_target),
    .dmem_busy     (dmem_busy),
    .pc_en         (pc_en),
    .if_id_en      (if_id_en),
    .id_ex_en      (id_ex_en),
    .ex_mem_en     (ex_mem_en),
    .mem_wb_en     (mem_wb_en),
    .if_id_flush   (if_id_flush),
    .id_ex_flush   (id_ex_flush),
    .redirect      (redirect),
    .redirect_pc   (redirect_pc),
    .fwd_a         (fwd_a),
    .fwd_b         (fwd_b)
`ifdef HAZ_PERF_EN
    ,
    .stall_cycles  (stall_cycles),
    .redirect_count(redirect_count)
`endif
  );

  // Inputs change 1 time unit after posedge; checks happen 2 units later, well before the next edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    {id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd} = '0;
    {id_uses_rs1, id_uses_rs2, ex_is_load, mem_reg_write, wb_reg_write} = '0;
    ex_flush = 1'b0;
    dmem_busy = 1'b0;
    ex_pc_target = '0;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1'b1;
    ex_rs1 = 5'd3; mem_rd = 5'd3; mem_reg_write = 1'b1;
    ex_flush = 1'b1; ex_pc_target = 32'hdead_0000;
    tick(); tick();
    #2;
    checks++; if (en !== 5'b00000) begin errors++;
      $display("FAIL reset_en: got %b want 00000", en); end
    checks++; if ({if_id_flush, id_ex_flush} !== 2'b11) begin errors++;
      $display("FAIL reset_flush: got %b want 11", {if_id_flush, id_ex_flush}); end
    checks++; if (redirect !== 1'b0 || redirect_pc !== 32'h0) begin errors++;
      $display("FAIL reset_redirect: got %b/%h want 0/0", redirect, redirect_pc); end
    checks++; if (fwd_a !== 2'b00 || fwd_b !== 2'b00) begin errors++;
      $display("FAIL reset_fwd: got %b/%b want 00/00", fwd_a, fwd_b); end
    tick();
    rst = 1'b0;
    clear_inputs();
  endtask

  task automatic test_forward();
    ex_rs1 = 5'd5; mem_rd = 5'd5; mem_reg_write = 1'b1; wb_rd = 5'd5; wb_reg_write = 1'b1;
    #2;
    checks++; if (fwd_a !== 2'b01) begin errors++;
      $display("FAIL fwd_mem_prio: got %b want 01", fwd_a); end
    mem_reg_write = 1'b0;
    #2;
    checks++; if (fwd_a !== 2'b10) begin errors++;
      $display("FAIL fwd_wb: got %b want 10", fwd_a); end
    ex_rs1 = 5'd0; mem_rd = 5'd0; wb_rd = 5'd0; mem_reg_write = 1'b1;
    #2;
    checks++; if (fwd_a !== 2'b00) begin errors++;
      $display("FAIL fwd_x0: got %b want 00", fwd_a); end
    ex_rs2 = 5'd9; mem_rd = 5'd9; wb_rd = 5'd9; wb_reg_write = 1'b1;
    #2;
    checks++; if (fwd_b !== 2'b01 || fwd_a !== 2'b00) begin errors++;
      $display("FAIL fwd_b_mem: got %b/%b want 00/01", fwd_a, fwd_b); end
    mem_reg_write = 1'b0;
    #2;
    checks++; if (fwd_b !== 2'b10) begin errors++;
      $display("FAIL fwd_b_wb: got %b want 10", fwd_b); end
    clear_inputs();
    tick();
  endtask

  task automatic test_load_use();
    ex_is_load = 1'b1; ex_rd = 5'd7; id_rs2 = 5'd7; id_uses_rs2 = 1'b1;
    #2;
    checks++; if (en !== 5'b00111 || id_ex_flush !== 1'b1 || if_id_flush !== 1'b0) begin
      errors++;
      $display("FAIL lu_bubble: got en=%b idex_fl=%b ifid_fl=%b want 00111/1/0",
               en, id_ex_flush, if_id_flush); end
    tick();
    ex_is_load = 1'b0;
    #2;
    checks++; if (en !== 5'b11111 || id_ex_flush !== 1'b0) begin errors++;
      $display("FAIL lu_release: got en=%b idex_fl=%b want 11111/0", en, id_ex_flush); end
    // Load into x0 must not stall.
    ex_is_load = 1'b1; ex_rd = 5'd0; id_rs2 = 5'd0;
    #2;
    checks++; if (en !== 5'b11111 || id_ex_flush !== 1'b0) begin errors++;
      $display("FAIL lu_x0: got en=%b idex_fl=%b want 11111/0", en, id_ex_flush); end
    // rs2 matches but is not read: no stall.
    ex_rd = 5'd7; id_rs2 = 5'd7; id_uses_rs2 = 1'b0;
    #2;
    checks++; if (en !== 5'b11111) begin errors++;
      $display("FAIL lu_unused_rs: got en=%b want 11111", en); end
    clear_inputs();
    tick();
  endtask

  task automatic test_redirect();
    ex_is_load = 1'b1; ex_rd = 5'd7; id_rs1 = 5'd7; id_uses_rs1 = 1'b1;
    ex_flush = 1'b1; ex_pc_target = 32'h0000_3040;
    #2;
    checks++; if (redirect !== 1'b1 || redirect_pc !== 32'h0000_3040) begin errors++;
      $display("FAIL redir_pc: got %b/%h want 1/00003040", redirect, redirect_pc); end
    checks++; if ({if_id_flush, id_ex_flush} !== 2'b11 || en !== 5'b11111) begin errors++;
      $display("FAIL redir_ctrl: got fl=%b en=%b want 11/11111",
               {if_id_flush, id_ex_flush}, en); end
    tick();
    clear_inputs();
    #2;
    checks++; if (redirect !== 1'b0 || en !== 5'b11111) begin errors++;
      $display("FAIL redir_after: got %b en=%b want 0/11111", redirect, en); end
    tick();
  endtask

  task automatic test_deferred();
    dmem_busy = 1'b1; ex_flush = 1'b1; ex_pc_target = 32'h0000_5008;
    for (int i = 0; i < 3; i++) begin
      #2;
      checks++; if (en !== 5'b00000 || redirect !== 1'b0) begin errors++;
        $display("FAIL defer_busy%0d: got en=%b redir=%b want 00000/0", i, en, redirect); end
      tick();
    end
    dmem_busy = 1'b0; ex_flush = 1'b0; ex_pc_target = 32'h0;
    #2;
    checks++; if (en !== 5'b00000 || redirect !== 1'b0) begin errors++;
      $display("FAIL defer_release: got en=%b redir=%b want 00000/0", en, redirect); end
    tick();
    #2;
    checks++; if (redirect !== 1'b1 || redirect_pc !== 32'h0000_5008) begin errors++;
      $display("FAIL defer_redir: got %b/%h want 1/00005008", redirect, redirect_pc); end
    checks++; if ({if_id_flush, id_ex_flush} !== 2'b11 || en !== 5'b11111) begin errors++;
      $display("FAIL defer_ctrl: got fl=%b en=%b want 11/11111",
               {if_id_flush, id_ex_flush}, en); end
    tick();
    #2;
    checks++; if (redirect !== 1'b0 || en !== 5'b11111) begin errors++;
      $display("FAIL defer_run: got %b en=%b want 0/11111", redirect, en); end
    tick();
  endtask

  task automatic test_reset_mid_wait();
    dmem_busy = 1'b1; ex_flush = 1'b1; ex_pc_target = 32'h0000_1234;
    tick(); tick();
    rst = 1'b1;
    #2;
    checks++; if (en !== 5'b00000 || {if_id_flush, id_ex_flush} !== 2'b11 ||
                  redirect !== 1'b0) begin errors++;
      $display("FAIL rstwait_out: got en=%b fl=%b redir=%b want 00000/11/0",
               en, {if_id_flush, id_ex_flush}, redirect); end
    tick();
    rst = 1'b0; ex_flush = 1'b0; ex_pc_target = '0;
    dmem_busy = 1'b1;
    tick();
    dmem_busy = 1'b0;
    tick();
    #2;
    // A surviving pending redirect would show up here.
    checks++; if (redirect !== 1'b0 || en !== 5'b11111) begin errors++;
      $display("FAIL rstwait_pend: got redir=%b pc=%h en=%b want 0/11111",
               redirect, redirect_pc, en); end
    tick();
  endtask

`ifdef HAZ_PERF_EN
  task automatic test_perf();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    clear_inputs();
    for (int i = 0; i < 2; i++) begin
      ex_is_load = 1'b1; ex_rd = 5'd4; id_rs1 = 5'd4; id_uses_rs1 = 1'b1;
      tick();
      clear_inputs();
      tick();
    end
    // Two busy cycles plus the release cycle in MEM_WAIT: a 3-cycle freeze.
    dmem_busy = 1'b1;
    tick(); tick();
    dmem_busy = 1'b0;
    tick();
    ex_flush = 1'b1; ex_pc_target = 32'h100;
    tick(); tick();
    clear_inputs();
    #2;
    checks++; if (stall_cycles !== 32'd5) begin errors++;
      $display("FAIL perf_stall: got %0d want 5", stall_cycles); end
    checks++; if (redirect_count !== 32'd2) begin errors++;
      $display("FAIL perf_redir: got %0d want 2", redirect_count); end
    tick();
  endtask
`endif

  initial begin
    clear_inputs();
    rst = 1'b1;
    #1;
    test_reset();
    test_forward();
    test_load_use();
    test_redirect();
    test_deferred();
    test_reset_mid_wait();
`ifdef HAZ_PERF_EN
    test_perf();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
